// File: rtl/sysmgr_seq.sv
// Reset sequencer and fs timebase. Holds resets until a synchronised PLL lock has been
// seen, then releases rst_out bit by bit. Also generates the fs square wave, the fs strobe and a frame counter.
module sysmgr_seq #(
    parameter int RST_CYCLES  = 128,
    parameter int N_RST       = 2,
    parameter int STAGGER     = 16,
    parameter int FS_DIV_LOG2 = 8,
    parameter int LOCK_SYNC   = 2
) (
    input  logic             clk_256fs,
    input  logic             rst,
    input  logic             pll_lock,
    input  logic             sw_rst_req,
    input  logic             lock_lost_clr,
    output logic [N_RST-1:0] rst_out,
    output logic             clk_fs,
    output logic             fs_strobe,
    output logic [15:0]      frame_cnt,
    output logic             lock_lost,
    output logic             ready
);

    localparam int CNT_MAX = RST_CYCLES + (N_RST - 1) * STAGGER;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STRETCH   = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [N_RST-1:0]       rst_out_q, rst_out_d;
    logic                   ready_q, ready_d;
    logic                   lock_lost_q, lock_lost_d;
    logic [LOCK_SYNC-1:0]   sync_q, sync_d;
    logic [FS_DIV_LOG2-1:0] div_q, div_d;
    logic                   clk_fs_q, clk_fs_d;
    logic                   fs_strobe_q, fs_strobe_d;
    logic [15:0]            frame_cnt_q, frame_cnt_d;
    logic                   lock_s;
    logic                   lock_loss;

    assign lock_s = sync_q[LOCK_SYNC-1];

    always_comb begin
        sync_d      = {sync_q[LOCK_SYNC-2:0], pll_lock};
        state_d     = state_q;
        cnt_d       = cnt_q;
        rst_out_d   = rst_out_q;
        ready_d     = ready_q;
        lock_loss   = 1'b0;

        case (state_q)
            WAIT_LOCK: begin
                rst_out_d = '1;
                cnt_d     = '0;
                ready_d   = 1'b0;
                if (lock_s) state_d = STRETCH;
            end
            STRETCH: begin
                cnt_d = cnt_q + 1'b1;
                for (int i = 0; i < N_RST; i++) begin
                    if (int'(cnt_q) == RST_CYCLES + i * STAGGER - 1) begin
                        rst_out_d[i] = 1'b0;
                        if (i == N_RST - 1) begin
                            state_d = RUN;
                            ready_d = 1'b1;
                        end
                    end
                end
            end
            RUN: begin
                ready_d = 1'b1;
            end
            default: begin
                state_d = WAIT_LOCK;
            end
        endcase

        // Lock loss outranks a software request; both restart the release sequence.
        if (state_q != WAIT_LOCK) begin
            if (!lock_s) begin
                state_d   = WAIT_LOCK;
                cnt_d     = '0;
                rst_out_d = '1;
                ready_d   = 1'b0;
                lock_loss = 1'b1;
            end else if (sw_rst_req) begin
                state_d   = STRETCH;
                cnt_d     = '0;
                rst_out_d = '1;
                ready_d   = 1'b0;
            end
        end

        if (lock_loss)          lock_lost_d = 1'b1;
        else if (lock_lost_clr) lock_lost_d = 1'b0;
        else                    lock_lost_d = lock_lost_q;

        div_d = rst_out_q[0] ? '0 : div_q + 1'b1;
        // Gating with the next reset value keeps a stray strobe from escaping on re-entry.
        clk_fs_d    = div_q[FS_DIV_LOG2-1] & ~rst_out_d[0];
        fs_strobe_d = (&div_q) & ~rst_out_d[0];

        if (rst_out_q[0])     frame_cnt_d = '0;
        else if (fs_strobe_q) frame_cnt_d = frame_cnt_q + 16'd1;
        else                  frame_cnt_d = frame_cnt_q;
    end

    always_ff @(posedge clk_256fs) begin
        if (rst) begin
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            rst_out_q   <= '1;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b0;
            sync_q      <= '0;
            div_q       <= '0;
            clk_fs_q    <= 1'b0;
            fs_strobe_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rst_out_q   <= rst_out_d;
            ready_q     <= ready_d;
            lock_lost_q <= lock_lost_d;
            sync_q      <= sync_d;
            div_q       <= div_d;
            clk_fs_q    <= clk_fs_d;
            fs_strobe_q <= fs_strobe_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign rst_out   = rst_out_q;
    assign ready     = ready_q;
    assign lock_lost = lock_lost_q;
    assign clk_fs    = clk_fs_q;
    assign fs_strobe = fs_strobe_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_sysmgr_seq.sv
// Bench for sysmgr_seq: expectations are queued with their target cycle when stimulus is
// driven, then compared on the falling edge of that cycle.
module tb_sysmgr_seq;

    localparam int SIG_RST = 0, SIG_RDY = 1, SIG_LL = 2, SIG_FS = 3, SIG_CLK = 4, SIG_FC = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pll_lock = 1'b0;
    logic        sw_rst_req = 1'b0;
    logic        lock_lost_clr = 1'b0;
    logic [1:0]  rst_out;
    logic        clk_fs;
    logic        fs_strobe;
    logic [15:0] frame_cnt;
    logic        lock_lost;
    logic        ready;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        int          sig;
        logic [15:0] val;
        string       name;
    } exp_t;

    typedef struct {
        int          off;
        int          sig;
        logic [15:0] val;
        string       name;
    } vec_t;

    exp_t exp_q[$];
    vec_t rel_tbl[7];

    sysmgr_seq dut (
        .clk_256fs    (clk),
        .rst          (rst),
        .pll_lock     (pll_lock),
        .sw_rst_req   (sw_rst_req),
        .lock_lost_clr(lock_lost_clr),
        .rst_out      (rst_out),
        .clk_fs       (clk_fs),
        .fs_strobe    (fs_strobe),
        .frame_cnt    (frame_cnt),
        .lock_lost    (lock_lost),
        .ready        (ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] get_sig(input int sig);
        case (sig)
            SIG_RST: get_sig = {14'd0, rst_out};
            SIG_RDY: get_sig = {15'd0, ready};
            SIG_LL:  get_sig = {15'd0, lock_lost};
            SIG_FS:  get_sig = {15'd0, fs_strobe};
            SIG_CLK: get_sig = {15'd0, clk_fs};
            default: get_sig = frame_cnt;
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc == cyc) begin
                checks++;
                if (get_sig(exp_q[i].sig) !== exp_q[i].val) begin
                    failures++;
                    $display("FAIL %s @cyc %0d: got %h expected %h", exp_q[i].name, cyc,
                             get_sig(exp_q[i].sig), exp_q[i].val);
                end
                exp_q.delete(i);
            end
        end
    end

    task automatic push(input int c, input int sig, input logic [15:0] val, input string name);
        exp_t e;
        e.cyc = c; e.sig = sig; e.val = val; e.name = name;
        exp_q.push_back(e);
    endtask

    // base = edge at which the synchronised chain first samples pll_lock high
    // (or sw request edge minus two).
    task automatic push_release(input int base, input string tag);
        foreach (rel_tbl[k])
            push(base + rel_tbl[k].off, rel_tbl[k].sig, rel_tbl[k].val,
                 {tag, "_", rel_tbl[k].name});
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic push_reset_vals(input int c, input string tag);
        push(c, SIG_RST, 16'd3, {tag, "_rst_out"});
        push(c, SIG_RDY, 16'd0, {tag, "_ready"});
        push(c, SIG_LL,  16'd0, {tag, "_lock_lost"});
        push(c, SIG_FS,  16'd0, {tag, "_fs_strobe"});
        push(c, SIG_CLK, 16'd0, {tag, "_clk_fs"});
        push(c, SIG_FC,  16'd0, {tag, "_frame_cnt"});
    endtask

    initial begin
        rel_tbl[0] = '{129, SIG_RST, 16'd3, "rst_hold"};
        rel_tbl[1] = '{130, SIG_RST, 16'd2, "rst0_fall"};
        rel_tbl[2] = '{130, SIG_RDY, 16'd0, "ready_low"};
        rel_tbl[3] = '{145, SIG_RST, 16'd2, "rst1_hold"};
        rel_tbl[4] = '{145, SIG_RDY, 16'd0, "ready_pre"};
        rel_tbl[5] = '{146, SIG_RST, 16'd0, "rst1_fall"};
        rel_tbl[6] = '{146, SIG_RDY, 16'd1, "ready_rise"};

        push_reset_vals(2, "reset");
        push_reset_vals(3, "reset_hold");

        // Test 1: lock sampled at edge 10, release at 140 / 156
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(9);
        checks++;
        if (rst_out !== 2'b11) begin
            failures++;
            $display("FAIL wl_direct_rst_out: got %b", rst_out);
        end
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL wl_direct_ready: got %b", ready);
        end
        checks++;
        if (lock_lost !== 1'b0) begin
            failures++;
            $display("FAIL wl_direct_lock_lost: got %b", lock_lost);
        end
        pll_lock = 1'b1;
        push(100, SIG_RST, 16'd3, "wait_rst");
        push_release(10, "t1");
        push(146, SIG_LL, 16'd0, "t1_lock_lost");

        // Test 2: timebase relative to rst_out[0] fall at 140
        push(395, SIG_FS, 16'd0, "fs_pre");
        push(396, SIG_FS, 16'd1, "fs_first");
        push(397, SIG_FS, 16'd0, "fs_one_cycle");
        push(652, SIG_FS, 16'd1, "fs_second");
        push(268, SIG_CLK, 16'd0, "clk_low_end");
        push(269, SIG_CLK, 16'd1, "clk_rise");
        push(396, SIG_CLK, 16'd1, "clk_high_end");
        push(397, SIG_CLK, 16'd0, "clk_fall");
        push(396, SIG_FC, 16'd0, "fc_0");
        push(397, SIG_FC, 16'd1, "fc_1");
        push(653, SIG_FC, 16'd2, "fc_2");

        // Test 3: one-cycle lock drop sampled at 700
        wait_cyc(699);
        checks++;
        if (rst_out !== 2'b00) begin
            failures++;
            $display("FAIL run_direct_rst_out: got %b", rst_out);
        end
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL run_direct_ready: got %b", ready);
        end
        pll_lock = 1'b0;
        push(701, SIG_RST, 16'd0, "drop_rst_still");
        push(701, SIG_LL,  16'd0, "drop_ll_pre");
        push(702, SIG_RST, 16'd3, "drop_rst");
        push(702, SIG_LL,  16'd1, "drop_ll_set");
        push(702, SIG_RDY, 16'd0, "drop_ready");
        push(703, SIG_FC,  16'd0, "drop_fc");
        wait_cyc(700);
        pll_lock = 1'b1;
        push_release(701, "t3");
        push(850, SIG_LL, 16'd1, "ll_sticky");

        // Clear the sticky flag
        wait_cyc(899);
        checks++;
        if (lock_lost !== 1'b1) begin
            failures++;
            $display("FAIL ll_direct_sticky: got %b", lock_lost);
        end
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL rerun_direct_ready: got %b", ready);
        end
        lock_lost_clr = 1'b1;
        push(899, SIG_LL, 16'd1, "ll_before_clr");
        push(900, SIG_LL, 16'd0, "ll_cleared");
        wait_cyc(900);
        lock_lost_clr = 1'b0;

        // Test 4: software reset sampled at 1000
        wait_cyc(999);
        sw_rst_req = 1'b1;
        push(999,  SIG_RST, 16'd0, "sw_rst_pre");
        push(1000, SIG_RST, 16'd3, "sw_rst_assert");
        push(1000, SIG_RDY, 16'd0, "sw_ready");
        push_release(998, "t4");
        push(1010, SIG_LL, 16'd0, "sw_ll");
        push(1144, SIG_LL, 16'd0, "sw_ll_end");
        wait_cyc(1000);
        sw_rst_req = 1'b0;

        // Test 5: clear coincides with a new lock-loss event (lock-loss cycle feeds edge 1202)
        wait_cyc(1199);
        pll_lock = 1'b0;
        wait_cyc(1201);
        lock_lost_clr = 1'b1;
        push(1201, SIG_LL,  16'd0, "t5_ll_pre");
        push(1202, SIG_LL,  16'd1, "t5_set_wins");
        push(1202, SIG_RST, 16'd3, "t5_rst");
        push(1203, SIG_LL,  16'd0, "t5_clr_alone");
        wait_cyc(1203);
        lock_lost_clr = 1'b0;

        // Test 4b: software request while waiting for lock has no effect
        wait_cyc(1249);
        sw_rst_req = 1'b1;
        push(1251, SIG_RST, 16'd3, "wl_sw_rst");
        push(1255, SIG_LL,  16'd0, "wl_sw_ll");
        push(1260, SIG_RDY, 16'd0, "wl_sw_ready");
        wait_cyc(1250);
        sw_rst_req = 1'b0;

        // Test 6: lock back at 1300, STRETCH from 1302, rst when cnt=50 (edge 1353)
        wait_cyc(1299);
        checks++;
        if (rst_out !== 2'b11) begin
            failures++;
            $display("FAIL wl2_direct_rst_out: got %b", rst_out);
        end
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL wl2_direct_ready: got %b", ready);
        end
        checks++;
        if (lock_lost !== 1'b0) begin
            failures++;
            $display("FAIL wl2_direct_lock_lost: got %b", lock_lost);
        end
        pll_lock = 1'b1;
        wait_cyc(1352);
        rst = 1'b1;
        push_reset_vals(1353, "mid_rst");
        wait_cyc(1353);
        rst = 1'b0;
        push_release(1354, "t6");

        // Frame counter wrap: strobes at 1740, 1996 after release at 1484
        wait_cyc(1800);
        force dut.frame_cnt_q = 16'hFFFF;
        #1;
        release dut.frame_cnt_q;
        push(1801, SIG_FC, 16'hFFFF, "fc_preload");
        push(1996, SIG_FC, 16'hFFFF, "fc_pre_wrap");
        push(1996, SIG_FS, 16'd1,    "fs_wrap_strobe");
        push(1997, SIG_FC, 16'd0,    "fc_wrap");

        wait_cyc(2100);
        foreach (exp_q[k]) begin
            checks++;
            failures++;
            $display("FAIL %s: never compared, cycle %0d", exp_q[k].name, exp_q[k].cyc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
